// File: rtl/pdp_trace_pkg.sv
// Shared types for the PDP-11 retire trace transmitter.
//   instr_type_e : coarse instruction class carried in every trace record
//   state_e      : control state of retire_trace_tx
//   trace_rec_t  : packed trace record, instruction word in the MSBs
//   classify()   : maps an instruction word to its instr_type_e
package pdp_trace_pkg;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    DOUBLE = 2'b00,
    SINGLE = 2'b01,
    BRANCH = 2'b10,
    HALT   = 2'b11
  } instr_type_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0]  word;
    logic [127:0] regs;
    logic [3:0]   flags;
    logic [63:0]  count;
    instr_type_e  itype;
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

  // Opcode bits [14:12] of 1..6 are the double-operand group; bits [14:11]
  // all zero with a non-zero [10:8] is the branch group. The all-zero
  // word is HALT and is tested first so it never lands in another class.
  function automatic instr_type_e classify(input logic [15:0] word);
    if (word == 16'h0000)
      return HALT;
    if (word[14:12] != 3'd0 && word[14:12] != 3'd7)
      return DOUBLE;
    if (word[14:11] == 4'd0 && word[10:8] != 3'd0)
      return BRANCH;
    return SINGLE;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with valid/ready handshakes on both sides.
//   in_valid/in_ready/in_data    : write side, push when both handshake bits are 1
//   out_valid/out_ready/out_data : read side, out_data shows the oldest entry,
//                                  forced to zero while the FIFO is empty
// No bypass: a push into a full FIFO is refused even if a pop happens on
// the same edge. DEPTH must be a power of two, >= 2.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, push, pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/retire_trace_tx.sv
// Retire trace transmitter: turns retired PDP-11 instructions into trace
// records (word, registers, flags, running count, instruction class),
// buffers them, and hands them to a display consumer.
//   retire_valid/retire_ready/retire_word/retire_regs/retire_flags : core side
//   trace_valid/trace_ready/trace_rec                              : consumer side
//   done : the HALT record has been taken by the consumer
// After a HALT is accepted no further retires are taken; queued records
// drain in order and the block parks in DONE until reset.
module retire_trace_tx
  import pdp_trace_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   retire_valid,
  output logic                   retire_ready,
  input  logic [15:0]            retire_word,
  input  logic [127:0]           retire_regs,
  input  logic [3:0]             retire_flags,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [TRACE_REC_W-1:0] trace_rec,
  output logic                   done
);

  state_e      state_q, state_d;
  logic [63:0] count_q, count_d;
  // Holds retire_ready low until the first edge after reset release.
  logic        ready_en_q, ready_en_d;
  logic        fifo_in_ready, fifo_out_valid;
  logic        accept, pop;
  trace_rec_t  rec_in, rec_out;

  assign retire_ready = ready_en_q && (state_q == ST_RUN) && fifo_in_ready;
  assign accept       = retire_valid && retire_ready;
  assign trace_valid  = fifo_out_valid;
  assign pop          = trace_valid && trace_ready;
  assign rec_out      = trace_rec_t'(trace_rec);
  assign done         = (state_q == ST_DONE);

  always_comb begin
    rec_in.word  = retire_word;
    rec_in.regs  = retire_regs;
    rec_in.flags = retire_flags;
    // The record carries the post-increment count; wraps naturally at 2^64.
    rec_in.count = count_q + 64'd1;
    rec_in.itype = classify(retire_word);
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ready_en_d = 1'b1;
    if (accept) count_d = rec_in.count;
    case (state_q)
      ST_RUN:   if (accept && rec_in.itype == HALT) state_d = ST_DRAIN;
      // Nothing is pushed in DRAIN, so the HALT record is the last one out.
      ST_DRAIN: if (pop && rec_out.itype == HALT)   state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
    end
  end

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (accept),
    .in_ready  (fifo_in_ready),
    .in_data   (rec_in),
    .out_valid (fifo_out_valid),
    .out_ready (trace_ready),
    .out_data  (trace_rec)
  );

endmodule
